// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage downstream of the MIPS ALU decoder. Two-register pipeline:
//   S1 (ID/EX) captures decoded control, operands and destination; S2 (EX/MEM)
//   holds the logic/LUI result. Valid/ready handshakes on both sides, with a
//   synchronous flush that squashes both stages.
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   flush                : synchronous squash of S1 and S2
//   in_valid / in_ready  : upstream handshake
//   alucontrol           : 8-bit operation code from the ALU decoder
//   srca, srcb, imm16    : operands and instruction immediate
//   waddr, regwrite      : destination register and writeback enable
//   out_valid / out_ready: downstream handshake
//   result               : registered ALU result
//   out_waddr            : registered destination
//   out_regwrite         : registered writeback enable (0 for illegal ops)
//   illegal_op           : registered unsupported-opcode flag
module alu_exec_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    alucontrol,
    input  logic [DW-1:0] srca,
    input  logic [DW-1:0] srcb,
    input  logic [15:0]   imm16,
    input  logic [RW-1:0] waddr,
    input  logic          regwrite,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [RW-1:0] out_waddr,
    output logic          out_regwrite,
    output logic          illegal_op
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_ANDI = 8'h59;
    localparam logic [7:0] OP_ORI  = 8'h5A;
    localparam logic [7:0] OP_XORI = 8'h5B;
    localparam logic [7:0] OP_LUI  = 8'h5C;

    // S1 (ID/EX) state
    logic          r_s1_valid;
    logic [7:0]    r_s1_ctrl;
    logic [DW-1:0] r_s1_a;
    logic [DW-1:0] r_s1_b;
    logic [15:0]   r_s1_imm;
    logic [RW-1:0] r_s1_waddr;
    logic          r_s1_rw;

    // S2 (EX/MEM) state
    logic          r_s2_valid;
    logic [DW-1:0] r_s2_result;
    logic [RW-1:0] r_s2_waddr;
    logic          r_s2_rw;
    logic          r_s2_ill;

    logic          w_s1_adv;
    logic          w_s1_load;
    logic          w_s2_load;
    logic [DW-1:0] w_imm_zx;
    logic [DW-1:0] w_res;
    logic          w_ill;

    // S1 may move forward when S2 is empty or S2 is being retired this cycle.
    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_s1_load = in_valid && in_ready && !flush;
    assign w_s2_load = r_s1_valid && w_s1_adv && !flush;

    assign w_imm_zx  = {{(DW-16){1'b0}}, r_s1_imm};

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (r_s1_ctrl)
            OP_AND:  w_res = r_s1_a & r_s1_b;
            OP_OR:   w_res = r_s1_a | r_s1_b;
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
            OP_ANDI: w_res = r_s1_a & w_imm_zx;
            OP_ORI:  w_res = r_s1_a | w_imm_zx;
            OP_XORI: w_res = r_s1_a ^ w_imm_zx;
            OP_LUI:  w_res = {r_s1_imm, {(DW-16){1'b0}}};
            OP_NOP:  w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ctrl  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_imm   <= '0;
            r_s1_waddr <= '0;
            r_s1_rw    <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_valid <= 1'b1;
            end else if (r_s1_valid && w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_load) begin
                r_s1_ctrl  <= alucontrol;
                r_s1_a     <= srca;
                r_s1_b     <= srcb;
                r_s1_imm   <= imm16;
                r_s1_waddr <= waddr;
                r_s1_rw    <= regwrite;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_waddr  <= '0;
            r_s2_rw     <= 1'b0;
            r_s2_ill    <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_s2_result <= w_res;
                r_s2_waddr  <= r_s1_waddr;
                r_s2_rw     <= r_s1_rw && !w_ill;
                r_s2_ill    <= w_ill;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign result       = r_s2_result;
    assign out_waddr    = r_s2_waddr;
    assign out_regwrite = r_s2_rw;
    assign illegal_op   = r_s2_ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage: a vector table applied back to
//   back with expected results held in a scoreboard queue, plus hand-written
//   sequences for back-pressure, flush and mid-stream reset.
module tb_alu_exec_stage;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [4:0]  wa;
        logic        rw;
        logic [31:0] er;
        logic        eill;
        logic        erw;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  wa;
        logic        rw;
        logic        ill;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  alucontrol = '0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic [15:0] imm16 = '0;
    logic [4:0]  waddr = '0;
    logic        regwrite = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_waddr;
    logic        out_regwrite;
    logic        illegal_op;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[13];
    vec_t va, vb, vc;

    alu_exec_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .imm16(imm16),
        .waddr(waddr), .regwrite(regwrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_waddr(out_waddr),
        .out_regwrite(out_regwrite), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        alucontrol = v.ctrl;
        srca       = v.a;
        srcb       = v.b;
        imm16      = v.imm;
        waddr      = v.wa;
        regwrite   = v.rw;
    endtask

    // Present v until accepted; expectation is queued at the accepting edge.
    task automatic send(input vec_t v);
        exp_t e;
        bit ok;
        ok = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.r = v.er; e.wa = v.wa; e.rw = v.erw; e.ill = v.eill; e.acc = cyc;
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every retired result is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.r);
                chk("out_waddr", {27'd0, out_waddr}, {27'd0, mon_e.wa});
                chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, mon_e.rw});
                chk("illegal_op", {31'd0, illegal_op}, {31'd0, mon_e.ill});
                if (lat_chk) chk("latency", cyc - mon_e.acc, 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ctrl   a             b             imm      wa     rw    exp result    ill   rw
        tbl[0]  = '{8'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'h0000, 5'd5,  1'b1, 32'h00F0_1234, 1'b0, 1'b1};
        tbl[1]  = '{8'h27, 32'h0000_0000, 32'h0000_0000, 16'h0000, 5'd6,  1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[2]  = '{8'h5A, 32'h1000_0000, 32'hDEAD_BEEF, 16'h00FF, 5'd7,  1'b1, 32'h1000_00FF, 1'b0, 1'b1};
        tbl[3]  = '{8'h5C, 32'h1111_1111, 32'h2222_2222, 16'hABCD, 5'd8,  1'b1, 32'hABCD_0000, 1'b0, 1'b1};
        tbl[4]  = '{8'h25, 32'h1234_0000, 32'h0000_5678, 16'h0000, 5'd9,  1'b0, 32'h1234_5678, 1'b0, 1'b0};
        tbl[5]  = '{8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0000, 5'd10, 1'b1, 32'hF0F0_0F0F, 1'b0, 1'b1};
        tbl[6]  = '{8'h59, 32'h1234_5678, 32'hFFFF_FFFF, 16'hFFFF, 5'd11, 1'b1, 32'h0000_5678, 1'b0, 1'b1};
        tbl[7]  = '{8'h5B, 32'hFFFF_FFFF, 32'h0000_0000, 16'h00FF, 5'd12, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b1};
        tbl[8]  = '{8'h5A, 32'h0000_0000, 32'hFFFF_FFFF, 16'h8001, 5'd13, 1'b1, 32'h0000_8001, 1'b0, 1'b1};
        tbl[9]  = '{8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 5'd14, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tbl[10] = '{8'h20, 32'hFFFF_FFFF, 32'h1234_5678, 16'h1234, 5'd15, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[11] = '{8'hFF, 32'hAAAA_AAAA, 32'h5555_5555, 16'hFFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[12] = '{8'h24, 32'hFFFF_FFFF, 32'h8000_0001, 16'h0000, 5'd1,  1'b1, 32'h8000_0001, 1'b0, 1'b1};

        // Reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_out_waddr", {27'd0, out_waddr}, 32'd0);
        chk("rst_out_regwrite", {31'd0, out_regwrite}, 32'd0);
        chk("rst_illegal_op", {31'd0, illegal_op}, 32'd0);

        // Vector table back to back: 2-cycle latency, one result per cycle
        lat_chk = 1'b1;
        for (int i = 0; i < 13; i++) send(tbl[i]);
        drain(20);
        lat_chk = 1'b0;

        // Back-pressure: two accepts, then S1 and S2 full and stalled
        va = '{8'h26, 32'hAAAA_5555, 32'hFFFF_0000, 16'h0000, 5'd7, 1'b1, 32'h5555_5555, 1'b0, 1'b1};
        vb = '{8'h25, 32'h0000_0001, 32'h0000_0002, 16'h0000, 5'd8, 1'b1, 32'h0000_0003, 1'b0, 1'b1};
        vc = '{8'h5C, 32'h0000_0000, 32'h0000_0000, 16'h1234, 5'd9, 1'b1, 32'h1234_0000, 1'b0, 1'b1};
        out_ready = 1'b0;
        fork
            begin
                send(va);
                send(vb);
                send(vc);
            end
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_result_hold", result, 32'h5555_5555);
                    chk("bp_waddr_hold", {27'd0, out_waddr}, 32'd7);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(20);

        // Flush with both stages full and a new input offered
        out_ready = 1'b0;
        send(va);
        send(vb);
        drive(vc);
        in_valid = 1'b1;
        flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        va = '{8'h24, 32'hFFFF_FFFF, 32'h0000_FFFF, 16'h0000, 5'd3, 1'b1, 32'h0000_FFFF, 1'b0, 1'b1};
        vb = '{8'h5A, 32'h0000_0000, 32'h0000_0000, 16'h0001, 5'd4, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
        send(va);
        send(vb);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_out_waddr", {27'd0, out_waddr}, 32'd0);
        chk("arst_out_regwrite", {31'd0, out_regwrite}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        vc = '{8'h5B, 32'h0000_000F, 32'h0000_0000, 16'hF0F0, 5'd10, 1'b1, 32'h0000_F0FF, 1'b0, 1'b1};
        lat_chk = 1'b1;
        send(vc);
        drain(10);
        lat_chk = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage sitting directly downstream of the ALU decoder in the MIPS datapath.
- Captures the decoded 8-bit alucontrol, operands and destination info into an ID/EX register.
- Computes the logic/LUI result and holds it in an EX/MEM output register.
- Valid/ready handshakes on both sides allow back-pressure; a synchronous flush squashes in-flight work.

Parameters:
- DW, 32, datapath width; fixed at 32 for LUI semantics.
- RW, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of both stage registers.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alucontrol  in  8  operation code from the ALU decoder.
- srca  in  DW  rs operand.
- srcb  in  DW  rt operand.
- imm16  in  16  instruction immediate.
- waddr  in  RW  destination register.
- regwrite  in  1  writeback enable.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- result  out  DW  ALU result.
- out_waddr  out  RW  registered destination.
- out_regwrite  out  1  registered writeback enable; forced 0 when op is illegal.
- illegal_op  out  1  registered flag: alucontrol was not a supported code.

Behaviour:
- Opcodes (team defines):
  - AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27 use srca/srcb.
  - ANDI 8'h59, ORI 8'h5A, XORI 8'h5B use srca and zero-extended imm16.
  - LUI 8'h5C gives {imm16,16'h0}.
  - Code 8'h00 is a NOP: result 0, no illegal flag.
  - Any other code gives result 0, illegal_op=1, out_regwrite=0.
- Stage S1 (ID/EX register):
  - Holds s1_valid, alucontrol, srca, srcb, imm16, waddr, regwrite.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - Load on in_valid & in_ready.
  - If S1 advances with no new input, s1_valid clears.
- Stage S2 (EX/MEM register):
  - Loads the combinational result of S1 when s1_valid & s1_adv.
  - out_valid = s2_valid.
  - out_valid=1 & out_ready=1 retires the result. s2_valid clears unless S1 advances in the same cycle.
- Latency:
  - 2 cycles from accepted input to out_valid when there is no back-pressure.
  - Throughput 1/cycle with out_ready held high.
- Stability: while out_valid=1 & out_ready=0, result/out_waddr/out_regwrite/illegal_op hold. S1 holds if full; in_ready=0 when both stages are full.
- Flush:
  - On the next edge, s1_valid=0 and s2_valid=0. Inputs presented that cycle are discarded.
  - in_ready is still computed normally, but no load occurs.
  - Flush has priority over all loads.
- Reset (async, rst_n=0): all valids 0, result 0, out_waddr 0, out_regwrite 0, illegal_op 0; in_ready reads 1 after reset.
- Reset mid-operation: all in-flight instructions are lost and no partial output is produced.
- Datapath registers of invalid stages are don't-care, but outputs must read 0 after reset.

Test Plan:
- AND, srca=32'hF0F0_1234, srcb=32'h0FF0_FFFF, waddr=5, regwrite=1, out_ready=1 -> two cycles later out_valid=1, result=32'h00F0_1234, out_waddr=5, out_regwrite=1.
- Back-to-back NOR(0,0), ORI(srca=32'h1000_0000, imm16=16'h00FF), LUI(imm16=16'hABCD) -> results 32'hFFFF_FFFF, 32'h1000_00FF, 32'hABCD_0000 on consecutive cycles.
- Back-pressure: out_ready=0 for 4 cycles while feeding 3 ops -> in_ready drops after 2 accepts; outputs stay stable; releasing out_ready drains all 3 in order.
- alucontrol=8'h20 with regwrite=1 -> illegal_op=1, out_regwrite=0, result=0.
- Flush with both stages full and in_valid=1 -> next cycle out_valid=0, nothing emerges later, in_ready=1.
- Deassert rst_n mid-stream for 1 cycle -> all outputs 0 immediately (asynchronously); the next accepted op completes with 2-cycle latency.
